// File: rtl/lane_dispatcher_pkg.sv
// rtl/lane_dispatcher_pkg.sv - lane type, lane constants and lane helper for lane_dispatcher
package lane_dispatcher_pkg;

    typedef logic [1:0] lane_t;

    localparam int NumLanes = 4;

    localparam lane_t LANE_A = 2'd0;
    localparam lane_t LANE_B = 2'd1;
    localparam lane_t LANE_C = 2'd2;
    localparam lane_t LANE_D = 2'd3;

    // Next lane in round-robin order; wraps d -> a through the 2-bit width.
    function automatic lane_t next_lane(input lane_t lane);
        return lane + lane_t'(1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count, head word visible combinationally
module sync_fifo #(
    parameter int Width = 18,
    parameter int Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FullCount = CW'(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i & ~empty_o;

    // Storage is never read before it is written, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata_i;
        end
    end

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata_o = r_mem[r_rptr];
    assign count_o = r_count;
    assign full_o  = (r_count == FullCount);
    assign empty_o = (r_count == '0);

endmodule

// File: rtl/lane_dispatcher.sv
// rtl/lane_dispatcher.sv - buffers tagged words and dispatches one per cycle to a 4-lane demux; LANE_DISPATCHER_RR_EN selects round-robin lanes
module lane_dispatcher
    import lane_dispatcher_pkg::*;
#(
    parameter int Width = 16,
    parameter int Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [Width-1:0]       in_data_i,
    input  logic [1:0]             in_dest_i,
    input  logic                   hold_i,
    output logic [1:0]             sel_o,
    output logic [Width-1:0]       value_o,
    output logic                   strobe_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int CW = $clog2(Depth) + 1;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    lane_t            w_dest;
    logic [Width+1:0] w_wdata;
    logic [Width+1:0] w_rdata;
    logic [CW-1:0]    w_count;

    lane_t            r_sel;
    logic [Width-1:0] r_value;
    logic             r_strobe;

    // Ready depends only on stored state; a full FIFO never bypasses.
    assign in_ready_o = ~w_full;
    assign w_push     = in_valid_i & ~w_full;
    assign w_pop      = ~w_empty & ~hold_i;

`ifdef LANE_DISPATCHER_RR_EN
    lane_t r_rr_lane;

    // Round-robin lane counter, advanced only when a word is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_lane <= LANE_A;
        end else if (w_push) begin
            r_rr_lane <= next_lane(r_rr_lane);
        end
    end

    assign w_dest = r_rr_lane;
`else
    assign w_dest = lane_t'(in_dest_i);
`endif

    assign w_wdata = {w_dest, in_data_i};

    sync_fifo #(
        .Width (Width + 2),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (w_wdata),
        .rdata_o (w_rdata),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Output stage: load head on pop; otherwise hold lane/value since the demux rewrites every cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sel    <= LANE_A;
            r_value  <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_pop;
            if (w_pop) begin
                r_sel   <= w_rdata[Width+1:Width];
                r_value <= w_rdata[Width-1:0];
            end
        end
    end

    assign sel_o    = r_sel;
    assign value_o  = r_value;
    assign strobe_o = r_strobe;
    assign count_o  = w_count;

endmodule

// File: tb/tb_lane_dispatcher.sv
// tb/tb_lane_dispatcher.sv - scoreboard bench for lane_dispatcher with queue-based reference model
module tb_lane_dispatcher;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk_i;
    logic             rst_ni;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_data_i;
    logic [1:0]       in_dest_i;
    logic             hold_i;
    logic [1:0]       sel_o;
    logic [WIDTH-1:0] value_o;
    logic             strobe_o;
    logic [2:0]       count_o;

    lane_dispatcher #(.Width(WIDTH), .Depth(DEPTH)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .in_dest_i  (in_dest_i),
        .hold_i     (hold_i),
        .sel_o      (sel_o),
        .value_o    (value_o),
        .strobe_o   (strobe_o),
        .count_o    (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [17:0] mdl_q[$];
    logic [17:0] sb_q[$];
    bit          mdl_strobe;
    int          mdl_rr;
    logic [1:0]  last_sel;
    logic [15:0] last_val;
    int          n_checks;
    int          n_errors;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, then apply the FIFO rules to the model after the edge.
    task automatic step(input logic v, input logic [1:0] d, input logic [15:0] data, input logic h);
        bit         do_push;
        bit         do_pop;
        logic [1:0] dst;
        in_valid_i = v;
        in_dest_i  = d;
        in_data_i  = data;
        hold_i     = h;
        do_pop  = (mdl_q.size() != 0) && !h;
        do_push = v && (mdl_q.size() != DEPTH);
`ifdef LANE_DISPATCHER_RR_EN
        dst = 2'(mdl_rr);
`else
        dst = d;
`endif
        @(posedge clk_i);
        #1;
        if (do_pop) sb_q.push_back(mdl_q.pop_front());
        if (do_push) begin
            mdl_q.push_back({dst, data});
            mdl_rr = (mdl_rr + 1) % 4;
        end
        mdl_strobe = do_pop;
    endtask

    task automatic do_reset();
        rst_ni     = 1'b0;
        in_valid_i = 1'b0;
        hold_i     = 1'b0;
        mdl_q.delete();
        sb_q.delete();
        mdl_strobe = 1'b0;
        last_sel   = 2'd0;
        last_val   = 16'd0;
        mdl_rr     = 0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // Monitor: compare DUT state with the model and pop the scoreboard on each strobe.
    always @(negedge clk_i) begin
        logic [17:0] exp_w;
        chk("count", int'(count_o), mdl_q.size());
        chk("in_ready", int'(in_ready_o), int'(mdl_q.size() != DEPTH));
        chk("strobe", int'(strobe_o), int'(mdl_strobe));
        if (strobe_o) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                exp_w = sb_q.pop_front();
                chk("sel", int'(sel_o), int'(exp_w[17:16]));
                chk("value", int'(value_o), int'(exp_w[15:0]));
                last_sel = exp_w[17:16];
                last_val = exp_w[15:0];
            end
        end else begin
            chk("sel_hold", int'(sel_o), int'(last_sel));
            chk("value_hold", int'(value_o), int'(last_val));
        end
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_ni     = 1'b0;
        in_valid_i = 1'b0;
        in_data_i  = '0;
        in_dest_i  = '0;
        hold_i     = 1'b0;
        mdl_strobe = 1'b0;
        mdl_rr     = 0;
        last_sel   = 2'd0;
        last_val   = 16'd0;
        #2;
        do_reset();
        step(1'b0, 2'd0, 16'h0, 1'b0);
        step(1'b0, 2'd0, 16'h0, 1'b1);

        step(1'b1, 2'd2, 16'h1234, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd1, 16'hdead, 1'b0);

        for (int i = 0; i < 5; i++) step(1'b1, 2'(i), 16'h0a00 + 16'(i), 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 16'h0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            logic [7:0] pat;
            logic [1:0] d;
            pat = 8'b10_00_01_11;
            d   = pat[2*(i%4) +: 2];
            step(1'b1, d, 16'hb000 + 16'(i), 1'b0);
        end
        step(1'b0, 2'd0, 16'h0, 1'b0);
        step(1'b0, 2'd0, 16'h0, 1'b0);

        for (int i = 0; i < 3; i++) step(1'b1, 2'd3, 16'hc000 + 16'(i), 1'b1);
        do_reset();
        step(1'b1, 2'd1, 16'h5a5a, 1'b0);
        step(1'b0, 2'd0, 16'h0, 1'b0);
        step(1'b0, 2'd0, 16'h0, 1'b0);

`ifdef LANE_DISPATCHER_RR_EN
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 2'd3, 16'hd000 + 16'(i), 1'b0);
        step(1'b0, 2'd0, 16'h0, 1'b0);
        step(1'b0, 2'd0, 16'h0, 1'b0);
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 3) != 0), 2'($urandom),
                     16'($urandom), 1'($urandom_range(0, 2) == 0));
            end
        end

        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 2'd0, 16'h0, 1'b0);
        @(negedge clk_i);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("model_drained", mdl_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
